// File: rtl/rs485_uart_tx.sv
// Half-duplex RS-485 transmitter: byte FIFO, DE/RE guard sequencing (setup, frames, hold)
// and 8N1/8N2 serialisation onto f_tx. All outputs are registered.
module rs485_uart_tx #(
  parameter int CLK_DIV   = 434,
  parameter int DE_SETUP  = 16,
  parameter int DE_HOLD   = 434,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       f_tx,
  output logic       f_re,
  output logic       f_de
);

  localparam int STOP_LEN = STOP_BITS * CLK_DIV;
  localparam int MAX_A    = (STOP_LEN > DE_SETUP) ? STOP_LEN : DE_SETUP;
  localparam int CNT_MAX  = (MAX_A > DE_HOLD) ? MAX_A : DE_HOLD;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(DE_SETUP - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(DE_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, DATA, STOP, HOLD} state_t;

  // Handshake: a byte is written at a rising edge where tx_valid and tx_ready are both 1;
  // tx_valid may be held across edges and each accepted edge stores one byte.

  logic [7:0]       mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             empty_q, wr_en, pop, full_n;
  logic [7:0]       head;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n, de_n, busy_n;

  assign wr_en    = tx_valid & tx_ready;
  assign wr_ptr_n = wr_en ? wr_ptr + (FIFO_AW+1)'(1) : wr_ptr;
  assign rd_ptr_n = pop ? rd_ptr + (FIFO_AW+1)'(1) : rd_ptr;
  assign full_n   = (wr_ptr_n[FIFO_AW] != rd_ptr_n[FIFO_AW]) &&
                    (wr_ptr_n[FIFO_AW-1:0] == rd_ptr_n[FIFO_AW-1:0]);
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty_q) state_n = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          pop = 1'b1; shreg_n = head; state_n = START; cnt_n = '0;
        end
      end
      START: begin
        if (cnt == BIT_LAST) begin
          state_n = DATA; cnt_n = '0; bit_idx_n = '0;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {1'b1, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          cnt_n = '0;
          if (!empty_q) begin
            pop = 1'b1; shreg_n = head; state_n = START;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // A late byte takes priority over hold expiry so the driver never drops.
        if (!empty_q) begin
          pop = 1'b1; shreg_n = head; state_n = START; cnt_n = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n = IDLE; cnt_n = '0;
        end
      end
      default: begin
        state_n = IDLE; cnt_n = '0;
      end
    endcase
    tx_n   = (state_n == START) ? 1'b0 : (state_n == DATA) ? shreg_n[0] : 1'b1;
    de_n   = (state_n != IDLE);
    busy_n = (state_n != IDLE) || (wr_ptr_n != rd_ptr_n);
  end

  // empty_q reflects the occupancy before the edge, so a new byte is noticed one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      empty_q  <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      f_tx     <= 1'b1;
      f_de     <= 1'b0;
      f_re     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      empty_q  <= (wr_ptr == rd_ptr);
      tx_ready <= ~full_n;
      tx_busy  <= busy_n;
      f_tx     <= tx_n;
      f_de     <= de_n;
      f_re     <= de_n;
    end
  end

endmodule

// File: tb/tb_rs485_uart_tx.sv
// Directed bench for rs485_uart_tx: frame decoder with expected-byte queue, edge-timing
// checks for DE/RE and frame starts, FIFO-full, late byte, reset abort and 8N2 period.
module tb_rs485_uart_tx;

  localparam int CLK_DIV  = 4;
  localparam int DE_SETUP = 2;
  localparam int DE_HOLD  = 3;
  localparam int FRAME    = 10 * CLK_DIV;
  localparam int CLK_DIV2 = 434;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_valid, tx_ready, tx_busy, f_tx, f_re, f_de;
  logic [7:0] tx_data;
  logic       rst2, tx_valid2, tx_ready2, tx_busy2, f_tx2, f_re2, f_de2;
  logic [7:0] tx_data2;

  rs485_uart_tx #(.CLK_DIV(CLK_DIV), .DE_SETUP(DE_SETUP), .DE_HOLD(DE_HOLD),
                  .STOP_BITS(1), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .f_tx(f_tx), .f_re(f_re), .f_de(f_de));

  rs485_uart_tx #(.CLK_DIV(CLK_DIV2), .DE_SETUP(DE_SETUP), .DE_HOLD(DE_HOLD),
                  .STOP_BITS(2), .FIFO_AW(2)) dut2 (
    .clk(clk), .rst(rst2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_busy(tx_busy2), .f_tx(f_tx2), .f_re(f_re2), .f_de(f_de2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_count = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         start2_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_count <= rst_count + 1;
  end

  // line watchers, sampled on the falling edge
  logic de_prev = 1'b0, busy_prev = 1'b0, tx2_prev = 1'b1;
  int de_rises = 0, de_falls = 0, rise_cyc = 0, fall_cyc = 0, busy_fall_cyc = 0;

  always @(negedge clk) begin
    check("de_eq_re", f_re, f_de);
    if (f_de === 1'b1 && de_prev === 1'b0) begin de_rises++; rise_cyc = cyc; end
    if (f_de === 1'b0 && de_prev === 1'b1) begin de_falls++; fall_cyc = cyc; end
    if (tx_busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc;
    if (f_tx2 === 1'b0 && tx2_prev === 1'b1) start2_q.push_back(cyc);
    de_prev   = f_de;
    busy_prev = tx_busy;
    tx2_prev  = f_tx2;
  end

  // frame decoder: samples each bit mid-period; a reset inside the frame abandons it
  task automatic rx_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [8:0] e;
    int snap;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && f_tx === 1'b0) begin
        start_q.push_back(cyc);
        snap = rst_count;
        b = '0;
        rx_wait(CLK_DIV/2);
        if (snap == rst_count) check("start_bit", f_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          rx_wait(CLK_DIV);
          b[i] = f_tx;
        end
        rx_wait(CLK_DIV);
        if (snap == rst_count) begin
          check("stop_bit", f_tx, 1'b1);
          e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("rx_byte", {24'd0, b}, {23'd0, e});
        end
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, r0, f0, n0, n;
    logic [7:0] exp_r;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    rst2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = '0;
    @(negedge clk);
    check("rst_f_tx", f_tx, 1'b1);
    check("rst_f_de", f_de, 1'b0);
    check("rst_f_re", f_re, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ready", tx_ready, 1'b0);
    check("rst2_ready", tx_ready2, 1'b0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1'b1);
    check("busy_after_rst", tx_busy, 1'b0);
    repeat (3) @(negedge clk);

    // 1: single byte 0xA5
    start_q.delete();
    base = cyc + 1; r0 = de_rises; f0 = de_falls;
    write_byte(8'hA5);
    wait_idle("t1_idle", 200);
    check("t1_de_rise_edge", rise_cyc - base, 2);
    check("t1_start_edge", start_q.size() > 0 ? start_q[0] - base : -1, DE_SETUP + 2);
    check("t1_de_fall_edge", fall_cyc - base, DE_SETUP + FRAME + DE_HOLD + 2);
    check("t1_busy_fall_edge", busy_fall_cyc - base, DE_SETUP + FRAME + DE_HOLD + 2);
    check("t1_frames", start_q.size(), 1);
    check("t1_de_cycles", (de_rises - r0) * 16 + (de_falls - f0), 17);
    check("t1_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // 2: back-to-back 0x00, 0xFF
    start_q.delete();
    base = cyc + 1; r0 = de_rises; f0 = de_falls;
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_idle("t2_idle", 300);
    check("t2_frames", start_q.size(), 2);
    check("t2_first_start", start_q.size() > 0 ? start_q[0] - base : -1, DE_SETUP + 2);
    check("t2_gap", start_q.size() > 1 ? start_q[1] - start_q[0] : -1, FRAME);
    check("t2_de_rises", de_rises - r0, 1);
    check("t2_de_falls", de_falls - f0, 1);
    check("t2_de_fall_edge", fall_cyc - base, DE_SETUP + 2 * FRAME + DE_HOLD + 2);
    check("t2_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // 3: tx_valid held 8 cycles from IDLE; expected acceptance pattern, bit i = edge i
    start_q.delete();
    exp_r = 8'b0010_1111;
    for (int i = 0; i < 8; i++) begin
      tx_data  = 8'h10 + 8'(i);
      tx_valid = 1'b1;
      check("t3_ready", tx_ready, exp_r[i]);
      if (exp_r[i]) exp_q.push_back(tx_data);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle("t3_idle", 600);
    check("t3_frames", start_q.size(), 5);
    check("t3_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // 4: late byte written at the second HOLD edge
    start_q.delete();
    base = cyc + 1; r0 = de_rises; f0 = de_falls;
    write_byte(8'hA5);
    wait_cyc(base + DE_SETUP + FRAME + 2);
    write_byte(8'h3C);
    wait_idle("t4_idle", 300);
    check("t4_frames", start_q.size(), 2);
    check("t4_second_start", start_q.size() > 1 ? start_q[1] - base : -1,
          DE_SETUP + FRAME + DE_HOLD + 2);
    check("t4_de_rises", de_rises - r0, 1);
    check("t4_de_falls", de_falls - f0, 1);
    check("t4_de_fall_edge", fall_cyc - base, DE_SETUP + 2 * FRAME + 2 * DE_HOLD + 2);
    check("t4_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // 5: reset during data bit 3 with two bytes still queued
    start_q.delete();
    base = cyc + 1;
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    wait_cyc(base + DE_SETUP + 2 + 4 * CLK_DIV);
    check("t5_in_bit3", f_tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_f_tx", f_tx, 1'b1);
    check("t5_rst_f_de", f_de, 1'b0);
    check("t5_rst_f_re", f_re, 1'b0);
    check("t5_rst_busy", tx_busy, 1'b0);
    check("t5_rst_ready", tx_ready, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    n0 = start_q.size(); r0 = de_rises;
    repeat (60) @(negedge clk);
    check("t5_no_frame", start_q.size(), n0);
    check("t5_no_de", de_rises - r0, 0);
    check("t5_busy_quiet", tx_busy, 1'b0);
    write_byte(8'h5A);
    wait_idle("t5_idle", 200);
    check("t5_new_frame", start_q.size(), n0 + 1);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: 8N2 at CLK_DIV=434, start edge to start edge of two 0xFF frames
    start2_q.delete();
    base = cyc + 1;
    tx_data2 = 8'hFF; tx_valid2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    n = 0;
    while (start2_q.size() < 2 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_starts", start2_q.size(), 2);
    check("t6_first_start", start2_q.size() > 0 ? start2_q[0] - base : -1, DE_SETUP + 2);
    check("t6_period", start2_q.size() > 1 ? start2_q[1] - start2_q[0] : -1, 11 * CLK_DIV2);
    check("t6_de_high", f_de2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
